// File: rtl/rv_decode_pkg.sv
// Shared decode types: base opcodes, instruction format tag
// and the decoded-entry bundle held in the stage registers.
package rv_decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    // XLEN-wide pc/imm live beside this bundle in the stage
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational format classifier and sign-extended
// immediate generator for the RV32I/RV64I base formats.
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt,
    output logic            o_illegal
);

    logic [6:0]      w_opc;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic            w_rv64;

    assign w_opc  = i_instr[6:0];
    assign w_rv64 = (XLEN == 64);

    assign w_imm_i = XLEN'($signed(i_instr[31:20]));
    assign w_imm_s = XLEN'($signed({i_instr[31:25],
                                    i_instr[11:7]}));
    assign w_imm_b = XLEN'($signed({i_instr[31], i_instr[7],
                                    i_instr[30:25],
                                    i_instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({i_instr[31],
                                    i_instr[19:12],
                                    i_instr[20],
                                    i_instr[30:21], 1'b0}));

    always_comb begin
        o_fmt = FMT_NONE;
        unique case (w_opc)
            OP_OP:     o_fmt = FMT_R;
            OP_OP32:   o_fmt = w_rv64 ? FMT_R : FMT_NONE;
            OP_IMM32:  o_fmt = w_rv64 ? FMT_I : FMT_NONE;
            OP_IMM, OP_LOAD, OP_JALR,
            OP_SYSTEM, OP_FENCE:
                       o_fmt = FMT_I;
            OP_STORE:  o_fmt = FMT_S;
            OP_BRANCH: o_fmt = FMT_B;
            OP_LUI, OP_AUIPC:
                       o_fmt = FMT_U;
            OP_JAL:    o_fmt = FMT_J;
            default:   o_fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        o_imm = '0;
        unique case (o_fmt)
            FMT_I:   o_imm = w_imm_i;
            FMT_S:   o_imm = w_imm_s;
            FMT_B:   o_imm = w_imm_b;
            FMT_U:   o_imm = w_imm_u;
            FMT_J:   o_imm = w_imm_j;
            default: o_imm = '0;
        endcase
    end

    assign o_illegal = (o_fmt == FMT_NONE) ||
                       (i_instr[1:0] != 2'b11);

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage with optional 2-entry skid buffer
// between fetch and register-read/issue.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    dec_t            w_dec;
    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    logic            w_illegal;
    logic            w_in_fire;
    logic            w_out_free;

    dec_t            r_out;
    logic [XLEN-1:0] r_out_pc;
    logic [XLEN-1:0] r_out_imm;
    logic            r_out_valid;
    dec_t            r_skid;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_imm;
    logic            r_skid_valid;

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr   (in_instr),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_dec         = '0;
        w_dec.opcode  = in_instr[6:0];
        w_dec.rd      = in_instr[11:7];
        w_dec.funct3  = in_instr[14:12];
        w_dec.rs1     = in_instr[19:15];
        w_dec.rs2     = in_instr[24:20];
        w_dec.funct7  = in_instr[31:25];
        w_dec.fmt     = w_fmt;
        w_dec.illegal = w_illegal;
    end

    assign in_ready   = SKID_EN ? !r_skid_valid
                                : (!r_out_valid || out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_out.fmt    <= FMT_NONE;
            r_out_pc     <= '0;
            r_out_imm    <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid.fmt   <= FMT_NONE;
            r_skid_pc    <= '0;
            r_skid_imm   <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            // skid is older than anything on the input
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_pc     <= r_skid_pc;
                r_out_imm    <= r_skid_imm;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_out       <= w_dec;
                r_out_pc    <= in_pc;
                r_out_imm   <= w_imm;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (SKID_EN && w_in_fire) begin
            r_skid       <= w_dec;
            r_skid_pc    <= in_pc;
            r_skid_imm   <= w_imm;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_out_pc;
    assign out_opcode  = r_out.opcode;
    assign out_rd      = r_out.rd;
    assign out_rs1     = r_out.rs1;
    assign out_rs2     = r_out.rs2;
    assign out_funct3  = r_out.funct3;
    assign out_funct7  = r_out.funct7;
    assign out_imm     = r_out_imm;
    assign out_fmt     = r_out.fmt;
    assign out_illegal = r_out.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: XLEN=32 and XLEN=64
// instances share the same stimulus and handshake.
module tb_rv_decode_stage;
    import rv_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [63:0] in_pc64;
    logic        out_ready;

    logic        rdy32, vld32, ill32;
    logic [31:0] pc32, imm32;
    logic [6:0]  opc32, f7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  f3_32, fmt32;

    logic        rdy64, vld64, ill64;
    logic [63:0] pc64, imm64;
    logic [6:0]  opc64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64, fmt64;

    int checks = 0;
    int errors = 0;

    assign in_pc64 = {32'h0, in_pc};

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(vld32), .out_ready(out_ready),
        .out_pc(pc32), .out_opcode(opc32), .out_rd(rd32),
        .out_rs1(rs1_32), .out_rs2(rs2_32),
        .out_funct3(f3_32), .out_funct7(f7_32),
        .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32)
    );

    rv_decode_stage #(.XLEN(64), .SKID_EN(1'b1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(vld64), .out_ready(out_ready),
        .out_pc(pc64), .out_opcode(opc64), .out_rd(rd64),
        .out_rs1(rs1_64), .out_rs2(rs2_64),
        .out_funct3(f3_64), .out_funct7(f7_64),
        .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_instr = '0; in_pc = '0;
        step(); step();
        checks++;
        if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs got v=%b r=%b exp v=0 r=1", vld32, rdy32);
        end
        checks++;
        if (fmt32 !== 3'(FMT_NONE) || imm32 !== 32'h0 || rd32 !== 5'd0 || pc32 !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got fmt=%0d imm=%h rd=%0d pc=%h exp fmt=6 zeros", fmt32, imm32, rd32, pc32);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_instr = 32'hFFF00093;
        in_pc = 32'h100; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        checks++;
        if (vld32 !== 1'b1 || rd32 !== 5'd1 || rs1_32 !== 5'd0 || pc32 !== 32'h100) begin
            errors++;
            $display("FAIL addi_fields got v=%b rd=%0d rs1=%0d pc=%h exp 1 1 0 100", vld32, rd32, rs1_32, pc32);
        end
        checks++;
        if (fmt32 !== 3'(FMT_I) || imm32 !== 32'hFFFFFFFF || ill32 !== 1'b0) begin
            errors++;
            $display("FAIL addi_imm got fmt=%0d imm=%h ill=%b exp 1 ffffffff 0", fmt32, imm32, ill32);
        end
        step();
        checks++;
        if (vld32 !== 1'b1 || rd32 !== 5'd1) begin
            errors++;
            $display("FAIL addi_hold got v=%b rd=%0d exp 1 1", vld32, rd32);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (vld32 !== 1'b0) begin
            errors++;
            $display("FAIL addi_drain got v=%b exp 0", vld32);
        end
    endtask

    task automatic test_store_jal();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'hFE20AE23; in_pc = 32'h200;
        step();
        checks++;
        if (fmt32 !== 3'(FMT_S) || rs1_32 !== 5'd1 || rs2_32 !== 5'd2 || f3_32 !== 3'd2 || f7_32 !== 7'h7F) begin
            errors++;
            $display("FAIL sw_fields got fmt=%0d rs1=%0d rs2=%0d f3=%0d f7=%h exp 2 1 2 2 7f", fmt32, rs1_32, rs2_32, f3_32, f7_32);
        end
        checks++;
        if (imm32 !== 32'hFFFFFFFC || opc32 !== 7'h23) begin
            errors++;
            $display("FAIL sw_imm got imm=%h opc=%h exp fffffffc 23", imm32, opc32);
        end
        in_instr = 32'h001000EF; in_pc = 32'h204;
        step();
        in_valid = 1'b0;
        checks++;
        if (fmt32 !== 3'(FMT_J) || rd32 !== 5'd1 || imm32 !== 32'h800 || pc32 !== 32'h204) begin
            errors++;
            $display("FAIL jal got fmt=%0d rd=%0d imm=%h pc=%h exp 5 1 800 204", fmt32, rd32, imm32, pc32);
        end
        step();
    endtask

    task automatic test_branch_lui();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'hFE000EE3;
        step();
        checks++;
        if (fmt32 !== 3'(FMT_B) || imm32 !== 32'hFFFFFFFC) begin
            errors++;
            $display("FAIL beq got fmt=%0d imm=%h exp 3 fffffffc", fmt32, imm32);
        end
        in_instr = 32'h800002B7;
        step();
        in_valid = 1'b0;
        checks++;
        if (fmt32 !== 3'(FMT_U) || rd32 !== 5'd5 || imm32 !== 32'h80000000) begin
            errors++;
            $display("FAIL lui32 got fmt=%0d rd=%0d imm=%h exp 4 5 80000000", fmt32, rd32, imm32);
        end
        checks++;
        if (fmt64 !== 3'(FMT_U) || rd64 !== 5'd5 || imm64 !== 64'hFFFFFFFF80000000) begin
            errors++;
            $display("FAIL lui64 got fmt=%0d rd=%0d imm=%h exp 4 5 ffffffff80000000", fmt64, rd64, imm64);
        end
        step();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'h00000000;
        step();
        checks++;
        if (ill32 !== 1'b1 || fmt32 !== 3'(FMT_NONE) || imm32 !== 32'h0) begin
            errors++;
            $display("FAIL ill_zero got ill=%b fmt=%0d imm=%h exp 1 6 0", ill32, fmt32, imm32);
        end
        in_instr = 32'h0000003B;
        step();
        in_valid = 1'b0;
        checks++;
        if (ill32 !== 1'b1 || fmt32 !== 3'(FMT_NONE) || imm32 !== 32'h0) begin
            errors++;
            $display("FAIL ill_op32 got ill=%b fmt=%0d imm=%h exp 1 6 0", ill32, fmt32, imm32);
        end
        checks++;
        if (ill64 !== 1'b0 || fmt64 !== 3'(FMT_R)) begin
            errors++;
            $display("FAIL op32_rv64 got ill=%b fmt=%0d exp 0 0", ill64, fmt64);
        end
        step();
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int rcvd = 0;
        int cyc  = 0;
        bit stall = 1'b0;
        while (cyc < 30 && rcvd < 6) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (sent < 6);
            in_instr  = {12'(sent + 1), 5'd0, 3'd0, 5'(sent + 1), 7'h13};
            in_pc     = 32'h1000 + 32'(4 * sent);
            if (!rdy32) stall = 1'b1;
            if (vld32 && out_ready) begin
                checks++;
                if (rd32 !== 5'(rcvd + 1) || imm32 !== 32'(rcvd + 1) || pc32 !== 32'h1000 + 32'(4 * rcvd)) begin
                    errors++;
                    $display("FAIL bp_order got rd=%0d imm=%h pc=%h exp rd=%0d", rd32, imm32, pc32, rcvd + 1);
                end
                rcvd++;
            end
            if (in_valid && rdy32) sent++;
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (rcvd !== 6 || sent !== 6 || stall !== 1'b1) begin
            errors++;
            $display("FAIL bp_count got rcvd=%0d sent=%0d stall=%b exp 6 6 1", rcvd, sent, stall);
        end
        checks++;
        if (vld32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_dup got v=%b exp 0", vld32);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rcvd = 0;
        int cyc  = 0;
        bit stall = 1'b0;
        out_ready = 1'b1;
        while (cyc < 30 && rcvd < 6) begin
            in_valid = (sent < 6);
            in_instr = {12'(sent + 11), 5'd0, 3'd0, 5'(sent + 11), 7'h13};
            if (!rdy32) stall = 1'b1;
            if (vld32) begin
                checks++;
                if (rd32 !== 5'(rcvd + 11)) begin
                    errors++;
                    $display("FAIL b2b_order got rd=%0d exp %0d", rd32, rcvd + 11);
                end
                rcvd++;
            end
            if (in_valid && rdy32) sent++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc !== 7 || stall !== 1'b0 || rcvd !== 6) begin
            errors++;
            $display("FAIL b2b_rate got cyc=%0d stall=%b rcvd=%0d exp 7 0 6", cyc, stall, rcvd);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00700393;
        step();
        in_instr = 32'h00800413;
        step();
        checks++;
        if (rdy32 !== 1'b0 || vld32 !== 1'b1) begin
            errors++;
            $display("FAIL flush_full got r=%b v=%b exp 0 1", rdy32, vld32);
        end
        in_instr = 32'h00900493; flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin
            errors++;
            $display("FAIL flush_both got v=%b r=%b exp 0 1", vld32, rdy32);
        end
        in_instr = 32'h00A00513;
        step();
        in_instr = 32'h00B00593; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (vld32) seen++;
            step();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_drop got seen=%0d exp 0", seen);
        end
        in_valid = 1'b1; in_instr = 32'h00C00613;
        step();
        in_valid = 1'b0;
        checks++;
        if (vld32 !== 1'b1 || rd32 !== 5'd12) begin
            errors++;
            $display("FAIL flush_after got v=%b rd=%0d exp 1 12", vld32, rd32);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h400;
        in_instr = 32'h00D00693;
        step();
        in_instr = 32'h00E00713;
        step();
        rst_n = 1'b0; in_instr = 32'h00F00793;
        step();
        checks++;
        if (vld32 !== 1'b0 || rdy32 !== 1'b1 || rd32 !== 5'd0 || imm32 !== 32'h0 || pc32 !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid got v=%b r=%b rd=%0d imm=%h pc=%h exp 0 1 0 0 0", vld32, rdy32, rd32, imm32, pc32);
        end
        checks++;
        if (fmt32 !== 3'(FMT_NONE) || ill32 !== 1'b0 || opc32 !== 7'h0) begin
            errors++;
            $display("FAIL rst_mid_fmt got fmt=%0d ill=%b opc=%h exp 6 0 0", fmt32, ill32, opc32);
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        checks++;
        if (vld32 !== 1'b0) begin
            errors++;
            $display("FAIL rst_skid got v=%b exp 0", vld32);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store_jal();
        test_branch_lui();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
